// File: rtl/act_requant_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | act_requant_packer                                                       |
// | Requantises sign-magnitude MAC results to 8-bit activations and packs    |
// | them into a lane vector handed downstream over valid/ready.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module act_requant_packer #(
    parameter int N_LANES = 62,
    parameter int ACC_W   = 21,
    parameter int ELEM_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ACC_W-1:0]            in_acc,
    input  logic                        in_last,
    input  logic                        relu_en,
    input  logic [4:0]                  shift,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N_LANES*ELEM_W-1:0]   out_vec,
    output logic [5:0]                  out_count
);

    localparam logic       c_fill      = 1'b0;
    localparam logic       c_hold      = 1'b1;
    localparam logic [5:0] c_last_lane = 6'(N_LANES - 1);

    logic                        r_state;
    logic [5:0]                  r_ptr;
    logic [5:0]                  r_count;
    logic [N_LANES*ELEM_W-1:0]   r_vec;

    logic [ACC_W-1:0]            w_half;
    logic [ACC_W-1:0]            w_r;
    logic [ELEM_W-2:0]           w_sat;
    logic                        w_zero;
    logic [ELEM_W-1:0]           w_elem;
    logic                        w_accept;
    logic                        w_done;

    // Rounding add is done on the full accumulator width; the magnitude is
    // one bit narrower, so the sum cannot overflow.
    always_comb begin
        w_half = '0;
        if (shift != 5'd0)
            w_half = {{(ACC_W-1){1'b0}}, 1'b1} << (shift - 5'd1);
        w_r    = ({1'b0, in_acc[ACC_W-2:0]} + w_half) >> shift;
        w_sat  = (w_r > ACC_W'(127)) ? 7'h7f : w_r[ELEM_W-2:0];
        // Shifts beyond 19 always yield zero; zero never carries a sign bit.
        w_zero = (shift >= 5'd20) || (w_r == '0) || (in_acc[ACC_W-1] && relu_en);
        w_elem = w_zero ? '0 : {in_acc[ACC_W-1], w_sat};
    end

    assign w_accept = in_valid && (r_state == c_fill);
    assign w_done   = (r_ptr == c_last_lane) || in_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_fill;
            r_ptr   <= '0;
            r_count <= '0;
            r_vec   <= '0;
        end else if (r_state == c_fill) begin
            if (w_accept) begin
                r_vec[r_ptr*ELEM_W +: ELEM_W] <= w_elem;
                if (w_done) begin
                    r_state <= c_hold;
                    r_count <= r_ptr + 6'd1;
                    r_ptr   <= '0;
                end else begin
                    r_ptr   <= r_ptr + 6'd1;
                end
            end
        end else if (out_ready) begin
            r_state <= c_fill;
            r_ptr   <= '0;
            r_count <= '0;
            r_vec   <= '0;
        end
    end

    assign in_ready  = (r_state == c_fill);
    assign out_valid = (r_state == c_hold);
    assign out_vec   = r_vec;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_act_requant_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_act_requant_packer                                                    |
// | Directed scoreboard bench for act_requant_packer.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_act_requant_packer;

    localparam int N_LANES = 62;
    localparam int ACC_W   = 21;
    localparam int ELEM_W  = 8;
    localparam int VW      = N_LANES * ELEM_W;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  in_acc;
    logic              in_last;
    logic              relu_en;
    logic [4:0]        shift;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_vec;
    logic [5:0]        out_count;

    act_requant_packer #(
        .N_LANES (N_LANES),
        .ACC_W   (ACC_W),
        .ELEM_W  (ELEM_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_last   (in_last),
        .relu_en   (relu_en),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int            n_asserts = 0;
    int            n_fail    = 0;
    logic [VW-1:0] vq[$];
    logic [5:0]    cq[$];
    logic [VW-1:0] exp_vec = '0;
    int            exp_ptr = 0;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model(input logic [20:0] acc, input logic relu, input logic [4:0] sh);
        int unsigned mag;
        int unsigned r;
        int          s;
        mag = acc[19:0];
        s   = sh;
        if (s >= 20) return 8'h00;
        r = (s == 0) ? mag : ((mag + (32'd1 << (s - 1))) >> s);
        if (r > 127) r = 127;
        if (r == 0 || (acc[20] && relu)) return 8'h00;
        return {acc[20], r[6:0]};
    endfunction

    // expe < 0 selects the model; otherwise expe is the literal expected element.
    task automatic beat(input logic [20:0] acc, input logic last, input logic relu,
                        input logic [4:0] sh, input int expe);
        logic [7:0] e;
        int         n;
        e        = (expe < 0) ? model(acc, relu, sh) : expe[7:0];
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        relu_en  = relu;
        shift    = sh;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", '0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_vec[exp_ptr*8 +: 8] = e;
        exp_ptr++;
        if (exp_ptr == N_LANES || last) begin
            vq.push_back(exp_vec);
            cq.push_back(exp_ptr[5:0]);
            exp_vec = '0;
            exp_ptr = 0;
        end
    endtask

    // Called on the negedge right after the completing beat.
    task automatic collect(input int hold);
        logic [VW-1:0] ev;
        logic [5:0]    ec;
        int            n;
        chk("out_valid_latency", out_valid, 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (vq.size() == 0) begin
            chk("scoreboard_empty", '0, 1);
            ev = '0;
            ec = '0;
        end else begin
            ev = vq.pop_front();
            ec = cq.pop_front();
        end
        chk("out_vec", out_vec, ev);
        chk("out_count", out_count, ec);
        chk("in_ready_hold", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_vec", out_vec, ev);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_vec", out_vec, '0);
        chk("post_hs_out_count", out_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 0; in_valid = 0; in_acc = '0; in_last = 0;
        relu_en = 0; shift = '0; out_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_vec", out_vec, '0);
        chk("reset_out_count", out_count, 0);
        rst_n = 1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);

        // Full vector, lane k = k
        for (int k = 0; k < N_LANES; k++)
            beat(21'(k * 128), 1'b0, 1'b0, 5'd7, k);
        collect(0);

        // Rounding and saturation, one lane each
        beat(21'd24, 1'b1, 1'b0, 5'd4, 8'h02);            collect(0);
        beat(21'd23, 1'b1, 1'b0, 5'd4, 8'h01);            collect(0);
        beat({1'b1, 20'd40}, 1'b1, 1'b0, 5'd4, 8'h83);    collect(0);
        beat(21'h0FFFFF, 1'b1, 1'b0, 5'd4, 8'h7F);        collect(0);

        // Negative zero and ReLU
        beat(21'h100000, 1'b1, 1'b0, 5'd4, 8'h00);        collect(0);
        beat({1'b1, 20'd300}, 1'b1, 1'b1, 5'd0, 8'h00);   collect(0);
        beat({1'b1, 20'd300}, 1'b1, 1'b0, 5'd0, 8'hFF);   collect(0);

        // Partial flush including an out-of-range shift, then backpressure
        beat(21'd1000, 1'b0, 1'b0, 5'd3, 8'h7D);
        beat(21'h0FFFFF, 1'b0, 1'b0, 5'd25, 8'h00);
        beat({1'b1, 20'd500}, 1'b0, 1'b0, 5'd2, -1);
        beat(21'd96, 1'b0, 1'b1, 5'd5, 8'h03);
        beat(21'd7, 1'b1, 1'b0, 5'd0, 8'h07);
        in_valid = 1'b1;
        in_acc   = 21'd1234;
        collect(10);
        beat(21'd5, 1'b1, 1'b0, 5'd1, 8'h03);
        collect(0);

        // Reset mid-fill discards partial data
        for (int k = 0; k < 30; k++)
            beat(21'($urandom_range(0, 21'h1FFFFF)), 1'b0, 1'b0, 5'd6, -1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_vec = '0;
        exp_ptr = 0;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_vec", out_vec, '0);
        chk("midreset_out_count", out_count, 0);
        chk("midreset_in_ready", in_ready, 1);
        for (int k = 0; k < N_LANES; k++)
            beat(21'($urandom_range(0, 21'h1FFFFF)), 1'b0, 1'(k % 3 == 0),
                 5'($urandom_range(0, 12)), -1);
        collect(2);

        // in_last on the final lane behaves like a plain full vector
        for (int k = 0; k < N_LANES; k++)
            beat(21'($urandom_range(0, 21'h1FFFFF)), 1'(k == N_LANES - 1), 1'b0,
                 5'd10, -1);
        collect(0);

        chk("scoreboard_drained", 32'(vq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
